// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 width codes, FSM states,
// latched-request payload and the access-alignment fault helper.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned IDX_W  = XLEN - LANE_W;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [F3_W-1:0] F3_B  = 3'b000;
  localparam logic [F3_W-1:0] F3_H  = 3'b001;
  localparam logic [F3_W-1:0] F3_WD = 3'b010;
  localparam logic [F3_W-1:0] F3_BU = 3'b100;
  localparam logic [F3_W-1:0] F3_HU = 3'b101;

  // Lane-select shift amounts: byte lane = addr[1:0], half lane = addr[1]
  localparam logic [2:0] BYTE_LANE_PAD = 3'b000;
  localparam logic [3:0] HALF_LANE_PAD = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic              write;
    logic [F3_W-1:0]   funct3;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  index;
    logic [XLEN-1:0]   wdata;
  } lsu_req_t;

  // Illegal width code, unsigned store, or misaligned half/word access
  function automatic logic access_fault(input logic              write,
                                        input logic [F3_W-1:0]   funct3,
                                        input logic [LANE_W-1:0] lane);
    logic flt;
    case (funct3)
      F3_B:    flt = 1'b0;
      F3_BU:   flt = write;
      F3_H:    flt = lane[0];
      F3_HU:   flt = write | lane[0];
      F3_WD:   flt = (lane != 2'b00);
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction/extension and
// sub-word store merge into a previously read memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   load_word,
  input  logic [XLEN-1:0]   base_word,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   load_value_c,
  output logic [XLEN-1:0]   merged_word_c
);

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  assign byte_c = load_word[{lane, BYTE_LANE_PAD} +: BYTE_W];
  assign half_c = load_word[{lane[1], HALF_LANE_PAD} +: HALF_W];

  always_comb begin
    load_value_c = '0;
    case (funct3)
      F3_B:    load_value_c = {{(XLEN-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_BU:   load_value_c = {{(XLEN-BYTE_W){1'b0}}, byte_c};
      F3_H:    load_value_c = {{(XLEN-HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_HU:   load_value_c = {{(XLEN-HALF_W){1'b0}}, half_c};
      F3_WD:   load_value_c = load_word;
      default: load_value_c = '0;
    endcase
  end

  // Replace only the addressed lane(s); full-word stores bypass the read word
  always_comb begin
    merged_word_c = base_word;
    case (funct3)
      F3_B:    merged_word_c[{lane, BYTE_LANE_PAD} +: BYTE_W] = store_data[BYTE_W-1:0];
      F3_H:    merged_word_c[{lane[1], HALF_LANE_PAD} +: HALF_W] = store_data[HALF_W-1:0];
      F3_WD:   merged_word_c = store_data;
      default: merged_word_c = base_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-addressed memory:
// fault decode, request latch, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [F3_W-1:0]   req_funct3,
  input  logic [XLEN-1:0]   req_address,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN-1:0]   mem_data_in,
  input  logic [XLEN-1:0]   mem_data_out
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q;
  logic [XLEN-1:0] word_q;

  logic            accept_c;
  logic            range_fault_c;
  logic            req_fault_c;
  logic            resp_fault_d;
  logic [XLEN-1:0] resp_rdata_d;
  logic [XLEN-1:0] load_value_c;
  logic [XLEN-1:0] merged_word_c;

  assign accept_c      = req_valid & req_ready;
  assign range_fault_c = ({{LANE_W{1'b0}}, req_address[XLEN-1:LANE_W]} >= XLEN'(MEM_WORDS));
  assign req_fault_c   = range_fault_c
                       | access_fault(req_write, req_funct3, req_address[LANE_W-1:0]);

  lsu_align u_align (
    .funct3        (req_q.funct3),
    .lane          (req_q.lane),
    .load_word     (mem_data_out),
    .base_word     (word_q),
    .store_data    (req_q.wdata),
    .load_value_c  (load_value_c),
    .merged_word_c (merged_word_c)
  );

  // Next state and the response payload captured on entry to RESP
  always_comb begin
    state_d      = state_q;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (req_fault_c) begin
            state_d      = ST_RESP;
            resp_fault_d = 1'b1;
          end else if (req_write && (req_funct3 == F3_WD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (req_q.write) begin
          state_d = ST_WRITE;
        end else begin
          state_d      = ST_RESP;
          resp_rdata_d = load_value_c;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
    end else begin
      req_ready  <= (state_d == ST_IDLE);
      resp_valid <= (state_d == ST_RESP);
      resp_fault <= resp_fault_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q  <= '0;
      word_q <= '0;
    end else begin
      if (accept_c) begin
        req_q <= '{write:  req_write,
                   funct3: req_funct3,
                   lane:   req_address[LANE_W-1:0],
                   index:  req_address[XLEN-1:LANE_W],
                   wdata:  req_wdata};
      end
      if (state_q == ST_READ) begin
        word_q <= mem_data_out;
      end
    end
  end

  // Memory port is decoded straight from state so reset kills mem_we at once
  assign mem_we      = (state_q == ST_WRITE);
  assign mem_address = (state_q == ST_IDLE) ? '0 : {{LANE_W{1'b0}}, req_q.index};
  assign mem_data_in = mem_we ? merged_word_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-array
// reference of the memory and the request rules.
module tb_load_store_unit;

  localparam int unsigned WORDS = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [31:0] mem [WORDS];
  logic [7:0]  gold [WORDS*4];
  int          we_total = 0;
  logic [31:0] we_addr  = '0;
  int          checks   = 0;
  int          errors   = 0;

  load_store_unit #(.MEM_WORDS(WORDS)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  assign mem_data_out = (mem_address < 32'(WORDS)) ? mem[mem_address[4:0]] : 32'h0;

  always @(posedge clock) begin
    if (mem_we) begin
      we_total <= we_total + 1;
      we_addr  <= mem_address;
      if (mem_address < 32'(WORDS)) mem[mem_address[4:0]] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: fault rules, extension, latency and byte-level memory update
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic flt, output logic [31:0] rd,
                       output int lat, output int we);
    int     size;
    longint v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt  = 1'b0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) flt = 1'b1;
    if (w && f3[2]) flt = 1'b1;
    if ((a % size) != 0) flt = 1'b1;
    if ((a >> 2) >= WORDS) flt = 1'b1;
    rd = '0;
    we = 0;
    if (flt) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < size; i++) gold[int'(a) + i] = 8'(d >> (8 * i));
      we  = 1;
      lat = (size == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(gold[int'(a) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      rd  = 32'(v);
      lat = 2;
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, output logic [31:0] got);
    logic        exp_flt;
    logic [31:0] exp_rd;
    int          exp_lat, exp_we, lat, n, we_before;
    model(w, f3, a, d, exp_flt, exp_rd, exp_lat, exp_we);
    n = 0;
    while (!req_ready && n < 8) begin @(negedge clock); n++; end
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = w;
    req_funct3  = f3;
    req_address = a;
    req_wdata   = d;
    we_before   = we_total;
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      req_write   = 1'($urandom);
      req_funct3  = 3'($urandom);
      req_address = $urandom;
      req_wdata   = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    if (!resp_valid) check("busy_ready", 32'(req_ready), 32'd0);
    while (!resp_valid && lat < 8) begin @(negedge clock); lat++; end
    got = resp_rdata;
    check("latency", 32'(lat), 32'(exp_lat));
    check("fault", 32'(resp_fault), 32'(exp_flt));
    check("rdata", resp_rdata, exp_rd);
    check("resp_ready", 32'(req_ready), 32'd0);
    check("resp_maddr", mem_address, a >> 2);
    check("resp_mdin", mem_data_in, 32'd0);
    check("we_count", 32'(we_total - we_before), 32'(exp_we));
    if (exp_we != 0) check("we_addr", we_addr, a >> 2);
    @(negedge clock);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [31:0] gold_word(input int idx);
    return {gold[4*idx+3], gold[4*idx+2], gold[4*idx+1], gold[4*idx]};
  endfunction

  initial begin
    logic [31:0] r;
    logic [2:0]  legal [5];
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
    for (int i = 0; i < WORDS * 4; i++) gold[i] = 8'h0;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = '0; req_address = '0; req_wdata = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_address, 32'd0);
    check("rst_mdin", mem_data_in, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < WORDS; i++) do_req(1'b1, 3'd2, 32'(4 * i), $urandom, 1'b0, r);

    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 1'b0, r);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 1'b0, r);
    check("lw_deadbeef", r, 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'hC, 32'h11223344, 1'b0, r);
    do_req(1'b1, 3'd0, 32'hD, 32'h000000AA, 1'b0, r);
    check("sb_word3", mem[3], 32'h1122AA44);

    do_req(1'b1, 3'd2, 32'h4, 32'h80FF7F01, 1'b0, r);
    do_req(1'b0, 3'd0, 32'h6, 32'h0, 1'b0, r); check("lb_6", r, 32'hFFFFFFFF);
    do_req(1'b0, 3'd4, 32'h6, 32'h0, 1'b0, r); check("lbu_6", r, 32'h000000FF);
    do_req(1'b0, 3'd1, 32'h6, 32'h0, 1'b0, r); check("lh_6", r, 32'hFFFF80FF);
    do_req(1'b0, 3'd5, 32'h4, 32'h0, 1'b0, r); check("lhu_4", r, 32'h00007F01);

    do_req(1'b0, 3'd2, 32'h2, 32'h0, 1'b0, r);
    do_req(1'b1, 3'd1, 32'h1, 32'h1234, 1'b0, r);
    do_req(1'b0, 3'd3, 32'h0, 32'h0, 1'b0, r);
    do_req(1'b0, 3'd2, 32'h80, 32'h0, 1'b0, r);
    do_req(1'b1, 3'd4, 32'h10, 32'h5, 1'b0, r);

    // Reset while an SB sits in WRITE: the write must be dropped with no response
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_address = 32'hD; req_wdata = 32'h55;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!mem_we && n < 6) begin @(negedge clock); n++; end
    end
    check("rst_mid_we_seen", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_rvalid", 32'(resp_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(negedge clock);
      check("rst_hold_rvalid", 32'(resp_valid), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("rst_rel_ready", 32'(req_ready), 32'd1);
    check("rst_rel_rvalid", 32'(resp_valid), 32'd0);
    do_req(1'b0, 3'd2, 32'hC, 32'h0, 1'b0, r);
    check("lw_after_rst", r, 32'h1122AA44);

    // req_valid held high, alternating stores and loads
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      f3 = legal[$urandom_range(0, 2)];
      a  = 32'($urandom_range(0, 127));
      a  = (f3 == 3'd2) ? (a & 32'hFFFF_FFFC) : (f3 == 3'd1) ? (a & 32'hFFFF_FFFE) : a;
      do_req(1'(i % 2 == 0), f3, a, $urandom, 1'b1, r);
    end
    req_valid = 1'b0;

    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
      do_req(1'($urandom), f3, a, $urandom, 1'b0, r);
    end

    for (int i = 0; i < WORDS; i++) check("mem_final", mem[i], gold_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
